// File: rtl/net_demo_pkg.sv
// Shared types and constants for the net sequence driver.
//   state_t       : driver FSM states
//   DEFAULT_WIDTH : default number of pattern bits per transfer
package net_demo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/net_sequence_driver_if.sv
// Handshake and serial-net bundle between a requester and the driver.
//   start/pattern/abort     : request side (master drives)
//   ready/busy/done/bit_cnt : status (slave drives)
//   net1/net2               : the two serial net stages (slave drives)
interface net_sequence_driver_if
  import net_demo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic             abort;
  logic             ready;
  logic             net1;
  logic             net2;
  logic             busy;
  logic             done;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output start, pattern, abort,
    input  ready, net1, net2, busy, done, bit_cnt
  );

  modport slave (
    input  start, pattern, abort,
    output ready, net1, net2, busy, done, bit_cnt
  );

endinterface

// File: rtl/net_delay_reg.sv
// One-clock delay register forming the second net stage.
//   clk, rst : clock, asynchronous active-high reset
//   d, q     : data in, data out one cycle later (reset value 0)
module net_delay_reg (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/net_sequence_driver.sv
// Serialises a captured pattern MSB first onto net1, with net2 trailing
// by one cycle, then flushes and pulses done.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/status/net bundle (slave side)
module net_sequence_driver
  import net_demo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  net_sequence_driver_if.slave  bus
);

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_net1;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_kill;
  logic             w_delay_d;
  logic             w_net2;

  // Abort only matters while a transfer is on the nets; in IDLE it also vetoes start.
  assign w_accept  = (r_state == S_IDLE) & bus.start & ~bus.abort;
  assign w_kill    = r_busy & bus.abort;
  // An abort must leave both net stages at 0 on the following cycle.
  assign w_delay_d = w_kill ? 1'b0 : r_net1;

  // Driver FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_net1    <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift   <= bus.pattern;
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (bus.abort) begin
            r_state   <= S_IDLE;
            r_net1    <= 1'b0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
          end else if (r_bit_cnt == CNT_FULL) begin
            // Last bit has had its cycle on net1; release the net.
            r_net1  <= 1'b0;
            r_state <= S_FLUSH;
          end else begin
            r_net1    <= r_shift[WIDTH-1];
            r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_FLUSH: begin
          if (bus.abort) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  net_delay_reg u_net2 (
    .clk (clk),
    .rst (rst),
    .d   (w_delay_d),
    .q   (w_net2)
  );

  assign bus.ready   = r_ready;
  assign bus.net1    = r_net1;
  assign bus.net2    = w_net2;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_net_sequence_driver.sv
module tb_net_sequence_driver;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  net_sequence_driver_if #(.WIDTH(W), .CW(CW)) bus ();

  net_sequence_driver #(.WIDTH(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a transfer is described by its age in cycles since acceptance.
  // age -1 = idle, 0 = accepted, 1..W = bit (W-age) on net1, W+1 = flush, W+2 = done.
  int          m_off;
  logic [W-1:0] m_pat;
  logic [CW-1:0] m_cnt;
  logic        m_net1, m_net2, m_busy, m_done, m_ready;

  task automatic model_reset();
    m_off = -1; m_pat = '0; m_cnt = '0;
    m_net1 = 1'b0; m_net2 = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ready = 1'b1;
  endtask

  task automatic model_edge(input logic s, input logic [W-1:0] p, input logic a);
    logic prev_net1;
    logic kill;
    prev_net1 = m_net1;
    kill = 1'b0;
    if (m_off == W + 2) begin
      m_off = -1;
    end else if (m_off == -1) begin
      if (s && !a) begin
        m_off = 0;
        m_pat = p;
      end
    end else if (a) begin
      m_off = -1;
      kill  = 1'b1;
      m_cnt = '0;
    end else begin
      m_off++;
    end
    if (m_off >= 0 && m_off <= W + 1) m_cnt = CW'((m_off > W) ? W : m_off);
    m_net1  = (m_off >= 1 && m_off <= W) ? m_pat[W - m_off] : 1'b0;
    m_net2  = kill ? 1'b0 : prev_net1;
    m_busy  = (m_off >= 0 && m_off <= W + 1);
    m_done  = (m_off == W + 2);
    m_ready = (m_off == -1);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, got, exp);
      end
  endtask

  task automatic check_all();
    chk("net1",    32'(bus.net1),    32'(m_net1));
    chk("net2",    32'(bus.net2),    32'(m_net2));
    chk("busy",    32'(bus.busy),    32'(m_busy));
    chk("done",    32'(bus.done),    32'(m_done));
    chk("ready",   32'(bus.ready),   32'(m_ready));
    chk("bit_cnt", 32'(bus.bit_cnt), 32'(m_cnt));
  endtask

  task automatic cycle(input logic s, input logic [W-1:0] p, input logic a);
    @(negedge clk);
    bus.start = s; bus.pattern = p; bus.abort = a;
    @(posedge clk);
    model_edge(s, p, a);
    #1;
    check_all();
  endtask

  int done_cnt;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.pattern = '0; bus.abort = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();

    // Pattern A5 accepted on the very first edge after reset release.
    cycle(1'b1, 8'hA5, 1'b0);
    done_cnt = 0;
    for (int i = 1; i <= 11; i++) begin
      cycle(1'b0, W'($urandom), 1'b0);
      if (i == 10) chk("a5_done_cycle10", 32'(bus.done), 32'd1);
    end

    // Start held high: back-to-back FF transfers.
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 8'hFF, 1'b0);
      if (bus.done) done_cnt++;
    end
    chk("ff_done_count", 32'(done_cnt), 32'd2);
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'hFF, 1'b0);

    // Pattern 81, abort during cycle 4.
    cycle(1'b1, 8'h81, 1'b0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 8'h81, 1'b0);
    cycle(1'b0, 8'h81, 1'b1);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h81, 1'b0);

    // Pattern 3C, async reset between edges in cycle 3.
    cycle(1'b1, 8'h3C, 1'b0);
    for (int i = 1; i <= 3; i++) cycle(1'b0, 8'h3C, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h3C, 1'b0);

    // Start and abort together in IDLE.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h55, 1'b1);
    chk("start_abort_idle_ready", 32'(bus.ready), 32'd1);
    cycle(1'b0, 8'h55, 1'b0);

    // Start with new pattern during SHIFT is ignored.
    cycle(1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'hC3, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);

    // Randomised traffic with occasional aborts.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 3) == 0, W'($urandom), ($urandom % 12) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/net_sequence_driver.md
NET_SEQUENCE_DRIVER -- requirements
Module: net_sequence_driver

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of pattern bits per transfer (legal 2..32).
REQ-002 Parameter CW, default $clog2(WIDTH+1), SHALL set the width of bit_cnt.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: one clock; reset is asynchronous and active-high.
REQ-005 Port start  input  1  SHALL request a transfer of the current pattern.
REQ-006 Port pattern  input  WIDTH  SHALL be the bit pattern to drive, sent MSB first.
REQ-007 Port abort  input  1  SHALL request synchronous cancellation of an active transfer.
REQ-008 Port ready  output  1  SHALL be high only in IDLE, when start is accepted.
REQ-009 Port net1  output  1  SHALL be the registered serial bit currently driven.
REQ-010 Port net2  output  1  SHALL be net1 delayed by exactly one clock (second net stage).
REQ-011 Port busy  output  1  SHALL be high in SHIFT and FLUSH.
REQ-012 Port done  output  1  SHALL be a one-cycle pulse at normal completion.
REQ-013 Port bit_cnt  output  CW  SHALL report the number of bits already driven on net1 in the current transfer.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, FLUSH, DONE; encoding is free.
REQ-015 IDLE: start=1 with ready=1 SHALL capture pattern into the shift register, clear bit_cnt and enter SHIFT.
REQ-016 First pattern bit (MSB) SHALL appear on net1 in the cycle after acceptance; net2 shows it one cycle later.
REQ-017 SHIFT: each cycle SHALL drive the next bit on net1 and increment bit_cnt; after the bit with bit_cnt reaching WIDTH, enter FLUSH.
REQ-018 FLUSH: exactly one cycle; net1 SHALL return to 0 while net2 carries the final bit; then enter DONE.
REQ-019 DONE: done=1 for one cycle, net1=net2=0, then IDLE; bit_cnt SHALL hold WIDTH until next acceptance.
REQ-020 Total accept-to-done latency SHALL be WIDTH+2 cycles; a new start is accepted no sooner than the cycle after done.
REQ-021 start while busy or in DONE SHALL be ignored and not queued; pattern changes after acceptance SHALL have no effect.
REQ-022 abort in SHIFT or FLUSH SHALL return to IDLE next cycle with net1=net2=0, bit_cnt=0, no done pulse.
REQ-023 abort and start both high in IDLE: abort wins, nothing captured.
REQ-024 abort in IDLE or DONE without start SHALL have no effect (DONE still pulses done).
REQ-025 bit_cnt SHALL never exceed WIDTH; no wrap.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, net1=0, net2=0, busy=0, done=0, bit_cnt=0, shift register 0, ready=1.
REQ-027 rst asserted mid-transfer SHALL discard the transfer; no done pulse after release.
REQ-028 First acceptance SHALL be possible in the first clock edge after rst deassertion.

Structure
REQ-029 Package net_demo_pkg SHALL hold the state typedef and the default WIDTH constant.
REQ-030 The net1-to-net2 one-cycle register SHALL be a sub-module net_delay_reg (clk, rst, d, q, reset value 0).

Verification
REQ-031 WIDTH=8, start with pattern=8'hA5 -> net1 1,0,1,0,0,1,0,1 in cycles 1..8, net2 same shifted one cycle, done in cycle 10.
REQ-032 pattern=8'hFF, start held high continuously -> transfers back-to-back, each done followed by acceptance the next cycle; no bits lost or duplicated.
REQ-033 pattern=8'h81, abort in cycle 4 -> IDLE in cycle 5, net1=net2=0, bit_cnt=0, no done.
REQ-034 rst asserted in cycle 3 of pattern=8'h3C, asynchronously between edges -> outputs zero before next edge, ready=1, no done after release.
REQ-035 start and abort together in IDLE with pattern=8'h55 -> ready stays 1, net1 stays 0, no transfer.
REQ-036 start pulsed during SHIFT with new pattern=8'h00 -> ignored; original pattern completes unchanged.
